svo_scanout: RTL and testbench

SVO_SCANOUT -- requirements
Module: svo_scanout

---
 rtl/svo_scanout.sv | 218 +++++++++++++++++++++
 tb/tb_svo_scanout.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svo_scanout.sv
// -----------------------------------------------------------------------------
// svo_scanout
//   Frame-buffer scanout engine. Fetches one frame of pixels from memory in
//   fixed-length bursts (one burst outstanding at a time), buffers them in a
//   pixel FIFO and streams them to a video encoder over an AXI-stream style
//   handshake. The first pixel of each frame is tagged with tuser.
//
// Ports
//   clk              single clock, rising edge
//   resetn           asynchronous active-low reset
//   enable           scanout run request, sampled only while idle
//   fb_base          byte address of the frame start (4-byte aligned)
//   mem_req/mem_addr burst read request and its start byte address
//   mem_gnt          request accepted this cycle
//   mem_rvalid/mem_rdata  returned read words (pixel in the low bits)
//   out_axis_*       pixel stream: tvalid/tready/tdata/tuser (start of frame)
//   busy             a frame is in progress
//   frame_done       one-cycle pulse after the last pixel of a frame is taken
// -----------------------------------------------------------------------------
module svo_scanout #(
    parameter int SVO_HOR_PIXELS     = 640,
    parameter int SVO_VER_PIXELS     = 480,
    parameter int SVO_BITS_PER_PIXEL = 24,
    parameter int BURST_LEN          = 16,
    parameter int FIFO_DEPTH         = 64
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          enable,
    input  logic [31:0]                   fb_base,
    output logic                          mem_req,
    output logic [31:0]                   mem_addr,
    input  logic                          mem_gnt,
    input  logic                          mem_rvalid,
    input  logic [31:0]                   mem_rdata,
    output logic                          out_axis_tvalid,
    input  logic                          out_axis_tready,
    output logic [SVO_BITS_PER_PIXEL-1:0] out_axis_tdata,
    output logic                          out_axis_tuser,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int PIX_TOTAL = SVO_HOR_PIXELS * SVO_VER_PIXELS;
    localparam int CNT_W     = $clog2(PIX_TOTAL + 1);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int BW        = $clog2(BURST_LEN + 1);

    localparam logic [CNT_W-1:0] PIX_LAST    = CNT_W'(PIX_TOTAL - 1);
    localparam logic [BW-1:0]    BURST_LAST  = BW'(BURST_LEN - 1);
    localparam logic [AW:0]      DEPTH       = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]      BURST_FREE  = (AW + 1)'(BURST_LEN);
    localparam logic [31:0]      BURST_BYTES = 32'(4 * BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]                   addr_reg;
    logic [CNT_W-1:0]              word_cnt_reg;   // words received this frame
    logic [BW-1:0]                 burst_cnt_reg;  // words received this burst
    logic                          busy_reg;
    logic [AW:0]                   wr_ptr_reg;
    logic [AW:0]                   rd_ptr_reg;
    logic [SVO_BITS_PER_PIXEL-1:0] fifo_mem [FIFO_DEPTH];
    logic                          out_valid_reg;
    logic [SVO_BITS_PER_PIXEL-1:0] out_data_reg;
    logic [CNT_W-1:0]              acc_cnt_reg;    // pixels accepted this frame
    logic                          frame_done_reg;

    logic [AW:0] fill;
    logic [AW:0] free;
    logic        fifo_empty;
    logic        fifo_wr;
    logic        fifo_rd;
    logic        accept;
    logic        last_accept;
    logic        start;
    logic        granted;

    // Only the pixel bits of a memory word are stored.
    logic unused_rdata;
    assign unused_rdata = &{1'b0, mem_rdata};

    assign fill        = wr_ptr_reg - rd_ptr_reg;
    assign free        = DEPTH - fill;
    assign fifo_empty  = (fill == '0);
    assign accept      = out_valid_reg && out_axis_tready;
    // Refill the output register whenever it is empty or being drained.
    assign fifo_rd     = !fifo_empty && (!out_valid_reg || out_axis_tready);
    assign last_accept = accept && (acc_cnt_reg == PIX_LAST);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        start      = 1'b0;
        granted    = 1'b0;
        fifo_wr    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // !busy_reg keeps a new frame from starting until the previous
                // one has fully drained downstream.
                if (enable && fifo_empty && !busy_reg) begin
                    start      = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                // Free space only grows while in this state, so once raised
                // the request stays up until granted.
                mem_req = (free >= BURST_FREE);
                if (mem_req && mem_gnt) begin
                    granted    = 1'b1;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                fifo_wr = mem_rvalid;
                if (mem_rvalid && (burst_cnt_reg == BURST_LAST)) begin
                    state_next = (word_cnt_reg == PIX_LAST) ? S_IDLE : S_REQ;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------- fetch datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_reg      <= '0;
            word_cnt_reg  <= '0;
            burst_cnt_reg <= '0;
            busy_reg      <= 1'b0;
        end else begin
            if (start) begin
                addr_reg      <= fb_base;
                word_cnt_reg  <= '0;
                burst_cnt_reg <= '0;
                busy_reg      <= 1'b1;
            end
            if (granted) begin
                addr_reg      <= addr_reg + BURST_BYTES;
                burst_cnt_reg <= '0;
            end
            if (fifo_wr) begin
                word_cnt_reg  <= word_cnt_reg + 1'b1;
                burst_cnt_reg <= burst_cnt_reg + 1'b1;
            end
            // The last pixel can only leave after the whole frame was fetched.
            if (last_accept) begin
                busy_reg <= 1'b0;
            end
        end
    end

    // ----------------------------------------------------------- pixel FIFO
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (fifo_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= mem_rdata[SVO_BITS_PER_PIXEL-1:0];
        end
    end

    // ------------------------------------------------ registered output stage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            acc_cnt_reg    <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            if (fifo_rd) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= fifo_mem[rd_ptr_reg[AW-1:0]];
            end else if (accept) begin
                out_valid_reg <= 1'b0;
            end
            if (accept) begin
                acc_cnt_reg <= last_accept ? '0 : acc_cnt_reg + 1'b1;
            end
            frame_done_reg <= last_accept;
        end
    end

    assign mem_addr        = addr_reg;
    assign out_axis_tvalid = out_valid_reg;
    assign out_axis_tdata  = out_data_reg;
    assign out_axis_tuser  = out_valid_reg && (acc_cnt_reg == '0);
    assign busy            = busy_reg;
    assign frame_done      = frame_done_reg;

endmodule

// File: tb/tb_svo_scanout.sv
// -----------------------------------------------------------------------------
// tb_svo_scanout
//   Self-checking bench for svo_scanout with a small frame (8x2 pixels,
//   4-word bursts, 8-entry FIFO). A memory responder returns a known pattern
//   per address; a reference model derives the expected request addresses and
//   pixel sequence of each frame directly from the frame base address.
// -----------------------------------------------------------------------------
module tb_svo_scanout;

    localparam int H     = 8;
    localparam int V     = 2;
    localparam int BPP   = 24;
    localparam int BURST = 4;
    localparam int DEPTH = 8;
    localparam int TOTAL = H * V;

    logic           clk;
    logic           resetn;
    logic           enable;
    logic [31:0]    fb_base;
    logic           mem_req;
    logic [31:0]    mem_addr;
    logic           mem_gnt;
    logic           mem_rvalid;
    logic [31:0]    mem_rdata;
    logic           out_axis_tvalid;
    logic           out_axis_tready;
    logic [BPP-1:0] out_axis_tdata;
    logic           out_axis_tuser;
    logic           busy;
    logic           frame_done;

    svo_scanout #(
        .SVO_HOR_PIXELS    (H),
        .SVO_VER_PIXELS    (V),
        .SVO_BITS_PER_PIXEL(BPP),
        .BURST_LEN         (BURST),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .enable         (enable),
        .fb_base        (fb_base),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .out_axis_tvalid(out_axis_tvalid),
        .out_axis_tready(out_axis_tready),
        .out_axis_tdata (out_axis_tdata),
        .out_axis_tuser (out_axis_tuser),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Memory contents: a scrambled function of the byte address, upper bits
    // deliberately non-zero so only the low pixel bits must be forwarded.
    function automatic logic [31:0] pix_of(input logic [31:0] a);
        logic [31:0] x;
        x = a * 32'h9E37_79B1;
        return x ^ {x[15:0], x[31:16]};
    endfunction

    // Reference model and responder state
    logic [31:0]    base_q[$];   // frame base each upcoming frame must use
    logic [BPP-1:0] pix_q[$];    // pixels expected downstream, in order
    logic [31:0]    exp_base = '0;
    int             req_words = 0;
    int             out_idx = 0;
    int             frames_done = 0;
    int             grants = 0;
    int             words_rx = 0;
    logic           done_exp = 1'b0;
    int             rsp_left = 0;
    logic [31:0]    rsp_addr = '0;
    int             gnt_wait = 0;
    int             gnt_delay = 0;
    int             gnt_mode = 0;      // <0: random 0..3, else fixed delay
    int             rvalid_pct = 100;
    int             tready_mode = 1;   // 0 low, 1 high, 2 random
    logic           junk_on = 1'b0;
    logic           req_prev = 1'b0;
    logic [31:0]    req_prev_addr = '0;
    logic           stall_prev = 1'b0;
    int             hold_run = 0;
    int             max_hold = 0;

    // Per-cycle model (at negedge, for the coming posedge) and drivers (#1
    // after posedge).
    initial begin
        logic [31:0]    tmp;
        logic [BPP-1:0] exp_pix;
        mem_gnt         = 1'b0;
        mem_rvalid      = 1'b0;
        mem_rdata       = '0;
        out_axis_tready = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                base_q.delete();
                pix_q.delete();
                req_words  = 0;
                out_idx    = 0;
                done_exp   = 1'b0;
                rsp_left   = 0;
                gnt_wait   = 0;
                req_prev   = 1'b0;
                stall_prev = 1'b0;
                hold_run   = 0;
            end else begin
                if (req_prev) begin
                    check_val("req_hold", 32'(mem_req), 32'd1);
                    check_val("addr_hold", mem_addr, req_prev_addr);
                end
                req_prev      = mem_req && !mem_gnt;
                req_prev_addr = mem_addr;
                if (mem_req && !mem_gnt) begin
                    hold_run++;
                    if (hold_run > max_hold) max_hold = hold_run;
                end

                check_val("frame_done", 32'(frame_done), 32'(done_exp));
                if (frame_done) check_val("busy_fall", 32'(busy), 32'd0);
                done_exp = 1'b0;

                if (stall_prev) check_val("hold_tvalid", 32'(out_axis_tvalid), 32'd1);
                stall_prev = out_axis_tvalid && !out_axis_tready;

                // returned words belong to the burst granted earlier
                if (mem_rvalid && rsp_left > 0) begin
                    rsp_left--;
                    rsp_addr += 32'd4;
                    words_rx++;
                end

                if (mem_req && mem_gnt) begin
                    if (req_words == 0) begin
                        if (base_q.size() == 0) begin
                            check_val("unexpected_frame", 32'd1, 32'd0);
                            exp_base = mem_addr;
                        end else begin
                            exp_base = base_q.pop_front();
                        end
                    end
                    check_val("req_addr", mem_addr, exp_base + 32'(4 * req_words));
                    check_val("busy_req", 32'(busy), 32'd1);
                    $display("REQ addr=0x%08h", mem_addr);
                    for (int i = 0; i < BURST; i++) begin
                        tmp = pix_of(exp_base + 32'(4 * (req_words + i)));
                        pix_q.push_back(tmp[BPP-1:0]);
                    end
                    req_words += BURST;
                    if (req_words == TOTAL) req_words = 0;
                    grants++;
                    rsp_left  = BURST;
                    rsp_addr  = mem_addr;
                    gnt_wait  = 0;
                    hold_run  = 0;
                    gnt_delay = (gnt_mode < 0) ? int'($urandom_range(3)) : gnt_mode;
                end

                if (out_axis_tvalid) begin
                    if (pix_q.size() == 0) begin
                        check_val("spurious_pixel", 32'd1, 32'd0);
                    end else begin
                        exp_pix = pix_q[0];
                        check_val("tdata", 32'(out_axis_tdata), 32'(exp_pix));
                        check_val("tuser", 32'(out_axis_tuser), 32'(out_idx == 0));
                        if (out_axis_tready) begin
                            void'(pix_q.pop_front());
                            out_idx++;
                            if (out_idx == TOTAL) begin
                                out_idx  = 0;
                                done_exp = 1'b1;
                                frames_done++;
                                $display("FRAME %0d complete", frames_done);
                            end
                        end
                    end
                end
            end

            @(posedge clk);
            #1;
            if (!resetn) begin
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b0;
            end else begin
                if (mem_req && rsp_left == 0) begin
                    if (gnt_wait >= gnt_delay) begin
                        mem_gnt = 1'b1;
                    end else begin
                        mem_gnt = 1'b0;
                        gnt_wait++;
                    end
                end else begin
                    mem_gnt = 1'b0;
                end
                if (rsp_left > 0) begin
                    mem_rvalid = ($urandom_range(99) < rvalid_pct);
                    mem_rdata  = pix_of(rsp_addr);
                end else if (junk_on) begin
                    mem_rvalid = 1'($urandom_range(1));
                    mem_rdata  = 32'hDEAD_BEEF;
                end else begin
                    mem_rvalid = 1'b0;
                end
                case (tready_mode)
                    0:       out_axis_tready = 1'b0;
                    1:       out_axis_tready = 1'b1;
                    default: out_axis_tready = 1'($urandom_range(1));
                endcase
            end
        end
    end

    task automatic wait_busy(input logic val, input string tag);
        int n;
        n = 0;
        while (busy !== val && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(busy), 32'(val));
    endtask

    // One frame: enable pulses until the frame starts, then fb_base is
    // scrambled so only the latched base may be used.
    task automatic run_frame(input logic [31:0] base);
        int f0;
        int g0;
        f0 = frames_done;
        g0 = grants;
        base_q.push_back(base);
        @(negedge clk);
        fb_base = base;
        enable  = 1'b1;
        wait_busy(1'b1, "start_busy");
        enable  = 1'b0;
        fb_base = base ^ 32'h00F0_0000;
        wait_busy(1'b0, "end_busy");
        repeat (6) @(negedge clk);
        check_val("frames", 32'(frames_done - f0), 32'd1);
        check_val("grants", 32'(grants - g0), 32'(TOTAL / BURST));
        check_val("idle_req", 32'(mem_req), 32'd0);
        check_val("pix_left", 32'(pix_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int w0;
        int n;
        resetn  = 1'b0;
        enable  = 1'b0;
        fb_base = 32'h0;
        repeat (3) @(negedge clk);
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_mem_addr", mem_addr, 32'd0);
        check_val("rst_tvalid", 32'(out_axis_tvalid), 32'd0);
        check_val("rst_tdata", 32'(out_axis_tdata), 32'd0);
        check_val("rst_tuser", 32'(out_axis_tuser), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #3 resetn = 1'b1;

        // Immediate memory, free-running sink: bursts at 0x1000..0x1030.
        gnt_mode = 0; gnt_delay = 0; rvalid_pct = 100; tready_mode = 1; junk_on = 1'b0;
        run_frame(32'h0000_1000);

        // Sink stalled: fetch stops once the FIFO cannot take a full burst.
        tready_mode = 0;
        w0 = words_rx;
        base_q.push_back(32'h0000_2000);
        @(negedge clk);
        fb_base = 32'h0000_2000;
        enable  = 1'b1;
        wait_busy(1'b1, "stall_start");
        enable = 1'b0;
        repeat (50) @(negedge clk);
        check_val("stall_words", 32'(words_rx - w0), 32'(DEPTH));
        check_val("stall_req", 32'(mem_req), 32'd0);
        check_val("stall_tvalid", 32'(out_axis_tvalid), 32'd1);
        tready_mode = 1;
        wait_busy(1'b0, "stall_end");
        repeat (6) @(negedge clk);
        check_val("stall_pix_left", 32'(pix_q.size()), 32'd0);

        // Grant held off 5 cycles on every request.
        gnt_mode = 5; gnt_delay = 5; max_hold = 0;
        run_frame(32'h0000_3000);
        check_val("gnt_hold_cycles", 32'(max_hold), 32'd5);
        gnt_mode = 0; gnt_delay = 0;

        // Reset while a burst is half received.
        base_q.push_back(32'h0000_5000);
        @(negedge clk);
        fb_base = 32'h0000_5000;
        enable  = 1'b1;
        n = 0;
        while (rsp_left != BURST - 2 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check_val("mid_burst_reached", 32'(rsp_left), 32'(BURST - 2));
        #3 resetn = 1'b0;
        enable = 1'b0;
        #1;
        check_val("arst_mem_req", 32'(mem_req), 32'd0);
        check_val("arst_mem_addr", mem_addr, 32'd0);
        check_val("arst_tvalid", 32'(out_axis_tvalid), 32'd0);
        check_val("arst_tdata", 32'(out_axis_tdata), 32'd0);
        check_val("arst_tuser", 32'(out_axis_tuser), 32'd0);
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_frame_done", 32'(frame_done), 32'd0);
        repeat (3) @(posedge clk);
        #3 resetn = 1'b1;
        junk_on = 1'b1;
        repeat (10) @(negedge clk);
        check_val("idle_junk_tvalid", 32'(out_axis_tvalid), 32'd0);
        check_val("idle_junk_busy", 32'(busy), 32'd0);
        run_frame(32'h0000_6000);

        // Random gaps everywhere, three frames at different bases.
        gnt_mode = -1; rvalid_pct = 60; tready_mode = 2; junk_on = 1'b1;
        run_frame(32'h0000_8000);
        run_frame(32'h0000_9000);
        run_frame(32'hFFFF_FFC0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
